font_fetch_ctrl: RTL
====================

# font_fetch_ctrl

Scanline prefetch sequencer for the VGA text-mode path. It walks one text row of the character buffer, issues one glyph lookup per column to the 256-bit font ROM, and slices out the 16-bit pixel row for the requested scanline. It writes one word per column into the line buffer that the pixel shifter reads during the next active line. It runs during horizontal blanking, driven by a per-line start pulse from the VGA timing generator.

## Interface
Parameters:
- COLS, 40, text columns per row
- ROWS, 30, text rows per screen
- CHAR_H, 16, glyph height in scanlines; also the row-slice width of font_data
- FONT_AW, 8, font ROM address width (character code)
- TXT_AW, 11, text RAM address width; must cover ROWS*COLS

Ports:
- clk  in  1  single system clock; all logic is on posedge
- rst  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle request to fetch for scanline line_y
- line_y  in  10  scanline to prepare, 0..ROWS*CHAR_H-1
- busy  out  1  high from the cycle after an accepted line_start until the cycle done is asserted
- done  out  1  one-cycle pulse after the last line-buffer write
- overrun  out  1  one-cycle pulse when line_start arrives while busy
- txt_addr  out  TXT_AW  text RAM read address; RAM has 1-cycle read latency
- txt_data  in  8  character code
- font_addr  out  FONT_AW  font ROM character address; ROM has 1-cycle read latency
- font_data  in  256  glyph bitmap; row r occupies bits [16r+15:16r]
- lb_we  out  1  line buffer write enable
- lb_waddr  out  6  column index being written
- lb_wdata  out  16  pixel row for that column
- cursor_col, cursor_row, cursor_on  in  6/5/1  cursor position and enable; present only with FONT_FETCH_CURSOR_EN

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - On line_start, latch glyph_row = line_y[3:0] and text_row = line_y >> 4.
  - Initialise the column counter to 0 and the base address to text_row*COLS. Compute the base by constant multiply; no general multiplier.
  - Go to FETCH.
- FETCH:
  - Each cycle, drive txt_addr = base + col and increment col.
  - After col = COLS-1 is issued, go to DRAIN.
- Three-stage pipeline, advancing one column per cycle:
  - S0: txt_addr issued.
  - S1: font_addr = txt_data.
  - S2: lb_wdata = font_data[16*glyph_row +: 16], lb_waddr = column, lb_we = 1.
  - Per-stage valid bits and column tags travel with the data.
- DRAIN: wait until the S2 valid bit clears, pulse done, then return to IDLE.
- Out-of-range line (text_row >= ROWS):
  - The FSM still runs COLS writes with lb_wdata = 0.
  - txt_addr is held at 0; no valid address is generated.
- line_start while busy: the request is ignored, overrun pulses in that cycle, and the current fetch is unaffected.
- line_start in the same cycle that done pulses: accepted; the FSM goes directly from DRAIN to FETCH state init.
- rst asserted mid-operation, in any state, on the next clock edge:
  - FSM returns to IDLE and all valid bits clear.
  - lb_we, busy, done and overrun go to 0.
  - No partial write occurs after the reset edge.

## Timing
- Reset values: busy=0, done=0, overrun=0, lb_we=0, txt_addr=0, font_addr=0, lb_waddr=0, lb_wdata=0.
- line_start sampled at cycle T:
  - First txt_addr at T+1 (busy high from T+1).
  - First lb_we at T+3.
  - Last lb_we at T+COLS+2.
  - done at T+COLS+3, with busy low in that same cycle.
- Default COLS=40: 43 cycles, well inside the 160-pixel-clock horizontal blank.
- lb_we is high for exactly COLS consecutive cycles, with lb_waddr running 0..COLS-1 in order.

## Configuration
- FONT_FETCH_CURSOR_EN defined:
  - The cursor ports exist.
  - In S2, when cursor_on=1, text_row==cursor_row and column==cursor_col, lb_wdata is inverted (XOR 16'hFFFF).
  - Cursor inputs are sampled at line_start.
- FONT_FETCH_CURSOR_EN undefined: the cursor ports and logic are absent; lb_wdata is always the unmodified glyph row.

## Structure
- Package vga_text_pkg holds:
  - the FSM state enum;
  - COLS, ROWS and CHAR_H defaults;
  - a localparam for the glyph-row bit slice width.
- One sub-module, font_fetch_pipe: the S0–S2 valid/tag/data pipeline, including the cursor inversion.
- The FSM and address counters stay in the top level.

## Test plan
- Scanline: text RAM row 2 filled with codes 0x41..0x68, ROM model with row r of code c = {c, r[7:0]}. line_start with line_y=37 → 40 writes at T+3..T+42, lb_wdata[col] = {0x41+col, 0x05}, done at T+43.
- Out of range: line_y=480 → 40 writes of 0x0000, txt_addr stays 0, done at T+43.
- Collision: line_start at T and again at T+10 → overrun pulse at T+10, still exactly 40 writes, single done.
- Back-to-back: second line_start coincident with done → accepted, second write burst starts 3 cycles later with no overrun.
- Reset mid-fetch: rst at T+20 → lb_we=0 from T+21, busy=0, no done; a fresh line_start then completes normally.
- Cursor (FONT_FETCH_CURSOR_EN): cursor_row=2, cursor_col=7, cursor_on=1, line_y=37 → column 7 word is ~{0x48, 0x05}; other columns unchanged.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared types and geometry defaults for the VGA text-mode fetch path.
// Pure declarations: no latency, no flow control.
package vga_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int COLS_DEF   = 40;
    localparam int ROWS_DEF   = 30;
    localparam int CHAR_H_DEF = 16;

    localparam int GLYPH_W = 16;
    localparam int GROW_W  = 4;
    localparam int COL_W   = 6;
    localparam int LINE_W  = 10;
    localparam int TXT_DW  = 8;

endpackage

// File: rtl/font_fetch_pipe.sv
// S0-S2 glyph pipeline: text code -> font address -> pixel row write (optional cursor invert).
// Latency 2 cycles from S0 to line-buffer write; no backpressure, one column per cycle.
module font_fetch_pipe
    import vga_text_pkg::*;
#(
    parameter int FONT_AW = 8,
    parameter int CHAR_H  = CHAR_H_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s0_vld,
    input  logic [COL_W-1:0]          s0_col,
    input  logic                      s0_blank,
    input  logic [GROW_W-1:0]         glyph_row,
`ifdef FONT_FETCH_CURSOR_EN
    input  logic                      cur_row_hit,
    input  logic [COL_W-1:0]          cur_col,
`endif
    input  logic [TXT_DW-1:0]         txt_data,
    input  logic [CHAR_H*GLYPH_W-1:0] font_data,
    output logic [FONT_AW-1:0]        font_addr,
    output logic                      s2_vld,
    output logic                      lb_we,
    output logic [COL_W-1:0]          lb_waddr,
    output logic [GLYPH_W-1:0]        lb_wdata
);

    localparam int SL_W = $clog2(CHAR_H * GLYPH_W);

    logic               s1_vld_q, s1_vld_d;
    logic [COL_W-1:0]   s1_col_q, s1_col_d;
    logic               s1_blank_q, s1_blank_d;
    logic               s2_vld_q, s2_vld_d;
    logic [COL_W-1:0]   s2_col_q, s2_col_d;
    logic               s2_blank_q, s2_blank_d;
    logic [SL_W-1:0]    slice_lsb;
    logic [GLYPH_W-1:0] glyph;

    always_comb begin
        s1_vld_d   = s0_vld;
        s1_col_d   = s0_col;
        s1_blank_d = s0_blank;
        s2_vld_d   = s1_vld_q;
        s2_col_d   = s1_col_q;
        s2_blank_d = s1_blank_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_col_q   <= '0;
            s1_blank_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_col_q   <= '0;
            s2_blank_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_col_q   <= s1_col_d;
            s1_blank_q <= s1_blank_d;
            s2_vld_q   <= s2_vld_d;
            s2_col_q   <= s2_col_d;
            s2_blank_q <= s2_blank_d;
        end
    end

    // Outputs are gated by stage valid so idle/reset presents all-zero buses.
    always_comb begin
        slice_lsb = SL_W'(glyph_row) << $clog2(GLYPH_W);
        glyph     = font_data[slice_lsb +: GLYPH_W];
        font_addr = '0;
        if (s1_vld_q && !s1_blank_q) begin
            font_addr = FONT_AW'(txt_data);
        end
        s2_vld   = s2_vld_q;
        lb_we    = s2_vld_q;
        lb_waddr = s2_vld_q ? s2_col_q : '0;
        lb_wdata = '0;
        if (s2_vld_q && !s2_blank_q) begin
            lb_wdata = glyph;
`ifdef FONT_FETCH_CURSOR_EN
            if (cur_row_hit && (s2_col_q == cur_col)) begin
                lb_wdata = glyph ^ {GLYPH_W{1'b1}};
            end
`endif
        end
    end

endmodule

// File: rtl/font_fetch_ctrl.sv
// Per-scanline glyph prefetch into the line buffer; cursor invert under FONT_FETCH_CURSOR_EN.
// First write 3 cycles after line_start, done at COLS+3; no backpressure, requests while busy flag overrun.
module font_fetch_ctrl
    import vga_text_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int CHAR_H  = CHAR_H_DEF,
    parameter int FONT_AW = 8,
    parameter int TXT_AW  = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      line_start,
    input  logic [LINE_W-1:0]         line_y,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic [TXT_AW-1:0]         txt_addr,
    input  logic [TXT_DW-1:0]         txt_data,
    output logic [FONT_AW-1:0]        font_addr,
    input  logic [CHAR_H*GLYPH_W-1:0] font_data,
`ifdef FONT_FETCH_CURSOR_EN
    input  logic [COL_W-1:0]          cursor_col,
    input  logic [4:0]                cursor_row,
    input  logic                      cursor_on,
`endif
    output logic                      lb_we,
    output logic [COL_W-1:0]          lb_waddr,
    output logic [GLYPH_W-1:0]        lb_wdata
);

    localparam int TROW_W = LINE_W - GROW_W;

    fetch_state_e        state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [TXT_AW-1:0]   base_q, base_d;
    logic [GROW_W-1:0]   glyph_row_q, glyph_row_d;
    logic                blank_q, blank_d;
`ifdef FONT_FETCH_CURSOR_EN
    logic                cur_row_hit_q, cur_row_hit_d;
    logic [COL_W-1:0]    cur_col_q, cur_col_d;
`endif

    logic [TROW_W-1:0]   text_row;
    logic                row_oor;
    logic                s0_vld;
    logic                s2_vld;
    logic                start_ok;

    assign text_row = line_y[LINE_W-1:GROW_W];
    assign row_oor  = (32'(text_row) >= 32'(ROWS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            base_q      <= '0;
            glyph_row_q <= '0;
            blank_q     <= 1'b0;
`ifdef FONT_FETCH_CURSOR_EN
            cur_row_hit_q <= 1'b0;
            cur_col_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            base_q      <= base_d;
            glyph_row_q <= glyph_row_d;
            blank_q     <= blank_d;
`ifdef FONT_FETCH_CURSOR_EN
            cur_row_hit_q <= cur_row_hit_d;
            cur_col_q     <= cur_col_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        base_d      = base_q;
        glyph_row_d = glyph_row_q;
        blank_d     = blank_q;
`ifdef FONT_FETCH_CURSOR_EN
        cur_row_hit_d = cur_row_hit_q;
        cur_col_d     = cur_col_q;
`endif
        start_ok = 1'b0;
        case (state_q)
            ST_IDLE:  start_ok = line_start;
            ST_FETCH: begin
                col_d = col_q + 1'b1;
                if (col_q == COL_W'(COLS - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s2_vld) begin
                    state_d  = ST_IDLE;
                    start_ok = line_start;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        // A request coinciding with done restarts straight from DRAIN.
        if (start_ok) begin
            state_d     = ST_FETCH;
            col_d       = '0;
            glyph_row_d = line_y[GROW_W-1:0];
            blank_d     = row_oor;
            base_d      = row_oor ? '0 : TXT_AW'(text_row) * TXT_AW'(COLS);
`ifdef FONT_FETCH_CURSOR_EN
            cur_row_hit_d = cursor_on && (text_row == TROW_W'(cursor_row));
            cur_col_d     = cursor_col;
`endif
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        s0_vld   = 1'b0;
        txt_addr = '0;
        case (state_q)
            ST_FETCH: begin
                busy   = 1'b1;
                s0_vld = 1'b1;
                if (!blank_q) begin
                    txt_addr = base_q + TXT_AW'(col_q);
                end
            end
            ST_DRAIN: begin
                busy = s2_vld;
                done = !s2_vld;
            end
            default: ;
        endcase
        overrun = line_start && busy;
    end

    font_fetch_pipe #(
        .FONT_AW (FONT_AW),
        .CHAR_H  (CHAR_H)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .s0_vld      (s0_vld),
        .s0_col      (col_q),
        .s0_blank    (blank_q),
        .glyph_row   (glyph_row_q),
`ifdef FONT_FETCH_CURSOR_EN
        .cur_row_hit (cur_row_hit_q),
        .cur_col     (cur_col_q),
`endif
        .txt_data    (txt_data),
        .font_data   (font_data),
        .font_addr   (font_addr),
        .s2_vld      (s2_vld),
        .lb_we       (lb_we),
        .lb_waddr    (lb_waddr),
        .lb_wdata    (lb_wdata)
    );

endmodule
